weight_stream_ctrl: RTL and testbench

//  Sequences one neuron's single-port weight ROM (1-cycle registered read, ren-gated, raddr
//  [ADDR_W:0]) and turns it into a valid/ready weight stream for the neuron MAC.
//  On start it reads NUM_WEIGHTS words in address order.
//  A 2-entry output FIFO absorbs the ROM latency, so downstream backpressure never drops a word.

---
 rtl/weight_stream_ctrl_if.sv | 24 ++
 rtl/weight_stream_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_weight_stream_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_ctrl_if.sv
// Valid/ready weight stream from the weight sequencer to the neuron MAC.
// The master drives valid/data/last and the slave drives ready.
interface weight_stream_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_last;

    modport master (
        output w_valid,
        output w_data,
        output w_last,
        input  w_ready
    );

    modport slave (
        input  w_valid,
        input  w_data,
        input  w_last,
        output w_ready
    );
endinterface

// File: rtl/weight_stream_ctrl.sv
// Reads one neuron's weight ROM in address order and streams the words through a 2-entry FIFO.
// Optional WSC_BASE_OFFSET_EN adds base_addr_i, latched at start, added to every read address.
module weight_stream_ctrl #(
    parameter int NUM_WEIGHTS = 784,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_ren_o,
    output logic [ADDR_W:0]     mem_raddr_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
`ifdef WSC_BASE_OFFSET_EN
    input  logic [ADDR_W:0]     base_addr_i,
`endif
    weight_stream_ctrl_if.master w_if
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W:0]     idx_q;
    logic [ADDR_W:0]     raddr_q;
    logic                inflight_q;
    logic                inflight_last_q;
`ifdef WSC_BASE_OFFSET_EN
    logic [ADDR_W:0]     base_q;
`endif

    // FIFO: entry 0 is the head presented on the stream, entry 1 is behind it.
    logic                v0_q;
    logic                v1_q;
    logic [DATA_W-1:0]   d0_q;
    logic [DATA_W-1:0]   d1_q;
    logic                l0_q;
    logic                l1_q;

    logic                pop_s;
    logic [1:0]          occ_s;
    logic [2:0]          pending_s;
    logic                issue_s;
    logic                is_last_issue_s;
    logic [ADDR_W:0]     issue_addr_s;

    // Issue decision: words held plus the one in flight, minus the one leaving now, must stay below 2.
    always_comb begin
        pop_s           = v0_q & w_if.w_ready;
        occ_s           = {1'b0, v0_q} + {1'b0, v1_q};
        pending_s       = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        is_last_issue_s = (idx_q == LAST_IDX);
`ifdef WSC_BASE_OFFSET_EN
        issue_addr_s    = base_q + idx_q;
`else
        issue_addr_s    = idx_q;
`endif
        if (state_q == S_FETCH) begin
            issue_s = (pending_s < 3'd2);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Output drive; the address holds the last issued value between reads.
    always_comb begin
        mem_ren_o   = issue_s;
        busy_o      = busy_q;
        done_o      = done_q;
        w_if.w_valid = v0_q;
        w_if.w_data  = d0_q;
        w_if.w_last  = l0_q;
        if (issue_s) begin
            mem_raddr_o = issue_addr_s;
        end else begin
            mem_raddr_o = raddr_q;
        end
    end

    // Pass sequencer: read index, in-flight tracking and busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            idx_q           <= '0;
            raddr_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef WSC_BASE_OFFSET_EN
            base_q          <= '0;
`endif
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue_s;
            inflight_last_q <= issue_s & is_last_issue_s;
            if (issue_s) begin
                raddr_q <= issue_addr_s;
                idx_q   <= idx_q + IDX_ONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
`ifdef WSC_BASE_OFFSET_EN
                        base_q  <= base_addr_i;
`endif
                    end
                end
                S_FETCH: begin
                    if (issue_s && is_last_issue_s) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop_s && l0_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry FIFO: push is the ROM return of last cycle's read, pop is the stream handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            d0_q <= '0;
            d1_q <= '0;
            l0_q <= 1'b0;
            l1_q <= 1'b0;
        end else begin
            case ({inflight_q, pop_s})
                2'b01: begin
                    v0_q <= v1_q;
                    d0_q <= d1_q;
                    l0_q <= v1_q & l1_q;
                    v1_q <= 1'b0;
                    l1_q <= 1'b0;
                end
                2'b10: begin
                    if (!v0_q) begin
                        v0_q <= 1'b1;
                        d0_q <= mem_rdata_i;
                        l0_q <= inflight_last_q;
                    end else begin
                        v1_q <= 1'b1;
                        d1_q <= mem_rdata_i;
                        l1_q <= inflight_last_q;
                    end
                end
                2'b11: begin
                    if (v1_q) begin
                        d0_q <= d1_q;
                        l0_q <= l1_q;
                        d1_q <= mem_rdata_i;
                        l1_q <= inflight_last_q;
                    end else begin
                        d0_q <= mem_rdata_i;
                        l0_q <= inflight_last_q;
                    end
                end
                default: begin
                    v0_q <= v0_q;
                    v1_q <= v1_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl: a 4-word instance and a 784-word instance, ROM models
// returning 16'h0100+addr, and a scoreboard of expected {last,data} words per instance.
module tb_weight_stream_ctrl;
    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a, start_b;
    logic          busy_a, done_a, ren_a;
    logic          busy_b, done_b, ren_b;
    logic [AW:0]   raddr_a, raddr_b;
    logic [DW-1:0] rdata_a, rdata_b;
`ifdef WSC_BASE_OFFSET_EN
    logic [AW:0]   base_a, base_b;
`endif

    weight_stream_ctrl_if #(.DATA_W(DW)) ifa ();
    weight_stream_ctrl_if #(.DATA_W(DW)) ifb ();

    weight_stream_ctrl #(.NUM_WEIGHTS(4), .ADDR_W(AW), .DATA_W(DW)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .mem_ren_o(ren_a), .mem_raddr_o(raddr_a), .mem_rdata_i(rdata_a),
`ifdef WSC_BASE_OFFSET_EN
        .base_addr_i(base_a),
`endif
        .w_if(ifa.master)
    );

    weight_stream_ctrl #(.NUM_WEIGHTS(784), .ADDR_W(AW), .DATA_W(DW)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .mem_ren_o(ren_b), .mem_raddr_o(raddr_b), .mem_rdata_i(rdata_b),
`ifdef WSC_BASE_OFFSET_EN
        .base_addr_i(base_b),
`endif
        .w_if(ifb.master)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW:0] a);
        logic [15:0] w;
        w = 16'h0100 + {5'd0, a};
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (ren_a) rdata_a <= rom_word(raddr_a);
        if (ren_b) rdata_b <= rom_word(raddr_b);
    end

    logic [DW:0] q_a[$];
    logic [DW:0] q_b[$];
    int tests = 0;
    int fails = 0;
    int iss_a = 0, pop_a = 0, iss_b = 0, pop_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0, last_cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: outstanding-word bound, scoreboard pop on each handshake, done/last counts.
    task automatic mon();
        logic [DW:0] e;
        chk("outstanding_a", 32'(iss_a - pop_a <= 2), 32'd1);
        chk("outstanding_b", 32'(iss_b - pop_b <= 2), 32'd1);
        if (ren_a) iss_a++;
        if (ren_b) iss_b++;
        if (ifa.w_valid && ifa.w_ready) begin
            pop_a++;
            if (q_a.size() == 0) begin
                chk("sb_unexpected_a", {15'd0, ifa.w_last, ifa.w_data}, 32'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                chk("w_word_a", {15'd0, ifa.w_last, ifa.w_data}, {15'd0, e});
            end
        end
        if (ifb.w_valid && ifb.w_ready) begin
            pop_b++;
            if (ifb.w_last) last_cnt_b++;
            if (q_b.size() == 0) begin
                chk("sb_unexpected_b", {15'd0, ifb.w_last, ifb.w_data}, 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                chk("w_word_b", {15'd0, ifb.w_last, ifb.w_data}, {15'd0, e});
            end
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    endtask

    task automatic adv();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        q_a.delete();
        iss_a = 0;
        pop_a = 0;
        done_cnt_a = 0;
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) q_a.push_back({1'(i == n - 1), rom_word((AW+1)'(i))});
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_busy"},  32'(busy_a), 32'd0);
        chk({tag, "_done"},  32'(done_a), 32'd0);
        chk({tag, "_ren"},   32'(ren_a), 32'd0);
        chk({tag, "_raddr"}, 32'(raddr_a), 32'd0);
        chk({tag, "_valid"}, 32'(ifa.w_valid), 32'd0);
        chk({tag, "_data"},  32'(ifa.w_data), 32'd0);
        chk({tag, "_last"},  32'(ifa.w_last), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [AW:0] ea;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        ifa.w_ready = 1'b1; ifb.w_ready = 1'b1;
`ifdef WSC_BASE_OFFSET_EN
        base_a = '0; base_b = '0;
`endif
        // Reset held two cycles with start asserted.
        repeat (2) @(posedge clk);
        #1;
        chk_idle_a("rst_a");
        chk("rst_b_busy",  32'(busy_b), 32'd0);
        chk("rst_b_ren",   32'(ren_b), 32'd0);
        chk("rst_b_raddr", 32'(raddr_b), 32'd0);
        chk("rst_b_valid", 32'(ifb.w_valid), 32'd0);
        chk("rst_b_last",  32'(ifb.w_last), 32'd0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        #1; adv(); #1;
        chk_idle_a("post_rst_a");
        chk("post_rst_b_busy", 32'(busy_b), 32'd0);

        // Full pass with w_ready held high.
        clear_a(); push_a(4);
        start_a = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) start_a = 1'b0;
            #1;
            chk("pass_ren", 32'(ren_a), 32'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk("pass_raddr", 32'(raddr_a), 32'(c - 1));
            if (c == 8) chk("pass_raddr_hold", 32'(raddr_a), 32'd3);
            chk("pass_busy",  32'(busy_a), 32'(c >= 1 && c <= 6));
            chk("pass_done",  32'(done_a), 32'(c == 7));
            chk("pass_valid", 32'(ifa.w_valid), 32'(c >= 3 && c <= 6));
            chk("pass_last",  32'(ifa.w_last), 32'(c == 6));
            adv();
        end
        chk("pass_sb_empty", 32'(q_a.size()), 32'd0);
        chk("pass_done_cnt", 32'(done_cnt_a), 32'd1);

        // Backpressure: w_ready low in cycles 3-8.
        clear_a(); push_a(4);
        for (int c = 0; c < 20; c++) begin
            start_a = (c == 0);
            ifa.w_ready = !(c >= 3 && c <= 8);
            #1;
            if (c <= 8) chk("bp_ren", 32'(ren_a), 32'(c == 1 || c == 2));
            if (c >= 3 && c <= 8) begin
                chk("bp_valid", 32'(ifa.w_valid), 32'd1);
                chk("bp_data_hold", 32'(ifa.w_data), 32'h0100);
            end
            adv();
        end
        ifa.w_ready = 1'b1;
        chk("bp_sb_empty", 32'(q_a.size()), 32'd0);
        chk("bp_done_cnt", 32'(done_cnt_a), 32'd1);
        chk("bp_issues", 32'(iss_a), 32'd4);

        // Start pulse during FETCH ignored, then reset in the cycle after the 2nd issue.
        clear_a(); push_a(4);
        for (int c = 0; c < 4; c++) begin
            start_a = (c == 0 || c == 2);
            rst = (c == 3);
            #1;
            if (c >= 1) begin
                chk("ign_ren", 32'(ren_a), 32'd1);
                chk("ign_raddr", 32'(raddr_a), 32'(c - 1));
            end
            adv();
        end
        rst = 1'b0; start_a = 1'b0;
        clear_a();
        #1;
        chk_idle_a("midrst_a");
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("midrst_no_done", 32'(done_a), 32'd0);
            chk("midrst_no_valid", 32'(ifa.w_valid), 32'd0);
            adv();
        end
        clear_a(); push_a(4);
        for (int c = 0; c < 10; c++) begin
            start_a = (c == 0);
            #1;
            if (c == 1) chk("replay_raddr0", 32'(raddr_a), 32'd0);
            if (c == 1) chk("replay_ren", 32'(ren_a), 32'd1);
            adv();
        end
        chk("replay_sb_empty", 32'(q_a.size()), 32'd0);
        chk("replay_done_cnt", 32'(done_cnt_a), 32'd1);

`ifdef WSC_BASE_OFFSET_EN
        // Base offset wrapping past the top of the address space.
        clear_a();
        for (int i = 0; i < 4; i++) begin
            ea = 11'h7FE + 11'(i);
            q_a.push_back({1'(i == 3), rom_word(ea)});
        end
        base_a = 11'h7FE;
        for (int c = 0; c < 10; c++) begin
            start_a = (c == 0);
            if (c == 1) base_a = '0;
            #1;
            if (c >= 1 && c <= 4) begin
                ea = 11'h7FE + 11'(c - 1);
                chk("ofs_raddr", 32'(raddr_a), 32'(ea));
            end
            adv();
        end
        chk("ofs_sb_empty", 32'(q_a.size()), 32'd0);
        chk("ofs_done_cnt", 32'(done_cnt_a), 32'd1);
`endif

        // 784-word pass with randomly toggling ready.
        for (int i = 0; i < 784; i++) q_b.push_back({1'(i == 783), rom_word((AW+1)'(i))});
        t = 0;
        while (done_cnt_b == 0 && t < 6000) begin
            start_b = (t == 0);
            ifb.w_ready = 1'($urandom_range(0, 1));
            #1;
            adv();
            t++;
        end
        chk("tog_done_in_time", 32'(done_cnt_b), 32'd1);
        ifb.w_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            adv();
        end
        chk("tog_sb_empty", 32'(q_b.size()), 32'd0);
        chk("tog_words", 32'(pop_b), 32'd784);
        chk("tog_last_cnt", 32'(last_cnt_b), 32'd1);
        chk("tog_done_cnt", 32'(done_cnt_b), 32'd1);
        chk("tog_busy_end", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
